// File: rtl/sha256_block_sequencer_if.sv
// Handshake and datapath bundle between the block source, the sequencer and hash_update.
// SHA224_MODE_EN adds the mode_224 message-mode select.
interface sha256_block_sequencer_if #(
   parameter int WK_LENGTH = 64
);
   localparam int IDX_W = $clog2(WK_LENGTH);

`ifdef SHA224_MODE_EN
   logic             mode_224;
`endif
   logic             start;
   logic             block_valid;
   logic             block_last;
   logic             block_ready;
   logic             hash_complete;
   logic [255:0]     updated_hash;
   logic             hu_enable;
   logic [IDX_W-1:0] wk_vector_index;
   logic             wk_index_complete;
   logic [255:0]     prev_hash;
   logic [255:0]     digest;
   logic             digest_valid;
   logic             busy;

   modport master (
`ifdef SHA224_MODE_EN
      output mode_224,
`endif
      output start, block_valid, block_last, hash_complete, updated_hash,
      input  block_ready, hu_enable, wk_vector_index, wk_index_complete,
      input  prev_hash, digest, digest_valid, busy
   );

   modport slave (
`ifdef SHA224_MODE_EN
      input  mode_224,
`endif
      input  start, block_valid, block_last, hash_complete, updated_hash,
      output block_ready, hu_enable, wk_vector_index, wk_index_complete,
      output prev_hash, digest, digest_valid, busy
   );
endinterface

// File: rtl/sha256_block_sequencer.sv
// Drives a single-round SHA-256 datapath across the blocks of a message and captures the digest.
// SHA224_MODE_EN: per-message SHA-224 IV selection and truncated digest.
module sha256_block_sequencer #(
   parameter int WK_LENGTH = 64
) (
   input logic                     clock,
   input logic                     reset,
   sha256_block_sequencer_if.slave seq
);
   localparam int               IDX_W    = $clog2(WK_LENGTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WK_LENGTH - 1);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_WAIT_BLK = 3'd1;
   localparam logic [2:0] ST_LOAD     = 3'd2;
   localparam logic [2:0] ST_ROUND    = 3'd3;
   localparam logic [2:0] ST_FINISH   = 3'd4;

   localparam logic [255:0] IV_256 = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

   logic [2:0]       state_r, state_s;
   logic [IDX_W-1:0] index_r, index_s;
   logic [255:0]     chain_r, chain_s;
   logic [255:0]     digest_r, digest_s;
   logic [255:0]     prev_hash_r;
   logic [255:0]     iv_s, capture_s;
   logic             first_block_r, first_block_s;
   logic             last_latched_r, last_latched_s;
   logic             digest_valid_r, digest_valid_s;
   logic             block_ready_r, hu_enable_r, wk_complete_r, busy_r;

`ifdef SHA224_MODE_EN
   localparam logic [255:0] IV_224 = {32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
                                      32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8};
   logic mode_r, mode_s;

   // The IV follows the mode being adopted; the truncation follows the mode held for the message.
   assign iv_s      = mode_s ? IV_224 : IV_256;
   assign capture_s = mode_r ? {32'h0000_0000, seq.updated_hash[223:0]} : seq.updated_hash;
`else
   assign iv_s      = IV_256;
   assign capture_s = seq.updated_hash;
`endif

   // Next-state, round index and chaining decisions
   always_comb begin
      state_s        = state_r;
      index_s        = index_r;
      chain_s        = chain_r;
      digest_s       = digest_r;
      first_block_s  = first_block_r;
      last_latched_s = last_latched_r;
      digest_valid_s = 1'b0;
`ifdef SHA224_MODE_EN
      mode_s         = mode_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (seq.start) begin
               state_s       = ST_WAIT_BLK;
               first_block_s = 1'b1;
`ifdef SHA224_MODE_EN
               mode_s        = seq.mode_224;
`endif
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WAIT_BLK: begin
            if (seq.block_valid) begin
               last_latched_s = seq.block_last;
               state_s        = ST_LOAD;
            end else begin
               state_s = ST_WAIT_BLK;
            end
         end
         ST_LOAD: begin
            index_s = {IDX_W{1'b0}};
            state_s = ST_ROUND;
         end
         ST_ROUND: begin
            if (index_r == LAST_IDX) begin
               state_s = ST_FINISH;
            end else begin
               index_s = index_r + IDX_W'(1);
            end
         end
         ST_FINISH: begin
            if (seq.hash_complete) begin
               chain_s       = seq.updated_hash;
               first_block_s = 1'b0;
               if (last_latched_r) begin
                  digest_s       = capture_s;
                  digest_valid_s = 1'b1;
                  state_s        = ST_IDLE;
               end else begin
                  state_s = ST_WAIT_BLK;
               end
            end else begin
               state_s = ST_FINISH;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State and registered outputs, decoded from the next state so they align with it
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r        <= ST_IDLE;
         index_r        <= {IDX_W{1'b0}};
         chain_r        <= 256'h0;
         digest_r       <= 256'h0;
         prev_hash_r    <= 256'h0;
         first_block_r  <= 1'b0;
         last_latched_r <= 1'b0;
         digest_valid_r <= 1'b0;
         block_ready_r  <= 1'b0;
         hu_enable_r    <= 1'b0;
         wk_complete_r  <= 1'b0;
         busy_r         <= 1'b0;
`ifdef SHA224_MODE_EN
         mode_r         <= 1'b0;
`endif
      end else begin
         state_r        <= state_s;
         index_r        <= index_s;
         chain_r        <= chain_s;
         digest_r       <= digest_s;
         prev_hash_r    <= first_block_s ? iv_s : chain_s;
         first_block_r  <= first_block_s;
         last_latched_r <= last_latched_s;
         digest_valid_r <= digest_valid_s;
         block_ready_r  <= (state_s == ST_WAIT_BLK);
         hu_enable_r    <= (state_s == ST_ROUND) || (state_s == ST_FINISH);
         wk_complete_r  <= ((state_s == ST_ROUND) && (index_s == LAST_IDX)) || (state_s == ST_FINISH);
         busy_r         <= (state_s != ST_IDLE);
`ifdef SHA224_MODE_EN
         mode_r         <= mode_s;
`endif
      end
   end

   assign seq.block_ready       = block_ready_r;
   assign seq.hu_enable         = hu_enable_r;
   assign seq.wk_vector_index   = index_r;
   assign seq.wk_index_complete = wk_complete_r;
   assign seq.prev_hash         = prev_hash_r;
   assign seq.digest            = digest_r;
   assign seq.digest_valid      = digest_valid_r;
   assign seq.busy              = busy_r;
endmodule

// File: doc/sha256_block_sequencer.md
Name: sha256_block_sequencer

Overview:
- Sequences the single-round SHA-256 compression datapath (`hash_update`) across one or more 512-bit blocks of a message.
- Drives the datapath's `enable`, round index, last-round flag and chaining value. Supplies the IV on the first block and chains the result into later blocks. Presents the final 256-bit digest.
- Sits between the message/W-K scheduler (which consumes `wk_vector_index`) and `hash_update`.

Parameters:
- WK_LENGTH, 64, rounds per block; round index width is $clog2(WK_LENGTH).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  1-cycle pulse; begins a new message
- block_valid  input  1  next block's W/K words are available upstream
- block_last  input  1  qualifies block_valid; this block is the message's last
- hash_complete  input  1  from datapath
- updated_hash  input  256  from datapath; word a in [31:0] … word h in [255:224]
- block_ready  output  1  sequencer accepts a block
- hu_enable  output  1  datapath enable
- wk_vector_index  output  $clog2(WK_LENGTH)  current round index
- wk_index_complete  output  1  last round / finalize flag to datapath
- prev_hash  output  256  chaining value to datapath (same packing)
- digest  output  256  final digest (same packing)
- digest_valid  output  1  1-cycle pulse, digest updated
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, reset=0): state=IDLE; all outputs 0; chain register 0; first_block=0; last_latched=0.
- States: IDLE, WAIT_BLK, LOAD, ROUND, FINISH.
- IDLE: start=1 → WAIT_BLK, first_block<=1. block_valid in IDLE ignored. start with block_valid in same cycle: start only.
- WAIT_BLK: block_ready=1. block_valid=1 → latch block_last into last_latched, then LOAD.
- LOAD (1 cycle): hu_enable=0 (datapath loads prev_hash); index<=0 → ROUND.
- ROUND: hu_enable=1; wk_vector_index=index, increments each cycle. wk_index_complete=1 only when index==WK_LENGTH-1; then → FINISH.
- FINISH: hu_enable=1, wk_index_complete=1 held. When hash_complete=1 (nominally first FINISH cycle):
  - chain<=updated_hash; first_block<=0.
  - If last_latched: digest<=updated_hash, digest_valid=1 for that cycle, → IDLE.
  - Else → WAIT_BLK.
- hash_complete=0 in FINISH: remain in FINISH.
- prev_hash = first_block ? IV : chain. Stable from LOAD through FINISH of each block.
- IV packing: [31:0]=6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, [255:224]=5be0cd19.
- Latency per block: 1 (LOAD) + WK_LENGTH (ROUND) + 1 (FINISH) = 66 cycles. The WAIT_BLK handshake adds ≥1 cycle.
- start while busy: ignored.
- digest holds its value until the next message completes.
- Reset mid-operation: immediate return to IDLE; the partial message is discarded; digest cleared.

Optional Feature:
- Macro: SHA224_MODE_EN.
- Defined:
  - Adds input `mode_224` (1 bit), sampled on start and held for the message.
  - When 1: IV = c1059ed8, 367cd507, 3070dd17, f70e5939, ffc00b31, 68581511, 64f98fa7, befa4fa4 (word a in [31:0]).
  - When 1: digest[255:224] forced to 0 at capture.
- Undefined: no port; SHA-256 only.

Test Plan:
- "abc" single padded block, block_last=1 → wk_vector_index runs 0..63 on consecutive cycles with wk_index_complete only at 63; digest[31:0]=ba7816bf, digest[255:224]=f20015ad; digest_valid one cycle; busy falls the same cycle.
- 56-byte "abcdbcdecdefdefg…nopq" as 2 blocks → prev_hash=IV for block 1 and chain for block 2; digest[31:0]=248d6a61, [255:224]=19db06c1; total ≥132 cycles.
- block_valid pulsed in IDLE, and start pulsed during ROUND → no state change, index unaffected, no digest_valid.
- reset asserted at wk_vector_index=30 → all outputs 0 asynchronously; the next start/"abc" run still produces ba7816bf…
- block_valid held low 10 cycles in WAIT_BLK between blocks → block_ready stays 1, no hu_enable activity, final digest unchanged.
- SHA224_MODE_EN with mode_224=1, "abc" → digest[31:0]=23097d22, [223:192]=e36c9da7, [255:224]=0.
